// File: rtl/rs_syndrome.sv
// RS(63,k) syndrome generator over GF(2^6) (x^6+x+1): Horner accumulation of S_1..S_NSYM.
// Optional macro RS_SYN_ZERO_SKIP_EN adds syn_skip and suppresses syn_vld for all-zero syndromes.
module rs_syndrome #(
    parameter int N    = 63,
    parameter int NSYM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_vld,
    input  logic [5:0]           din,
    input  logic                 sop,
    output logic                 busy,
    output logic                 syn_vld,
    output logic [6*NSYM-1:0]    syn_out,
    output logic                 syn_nz,
`ifdef RS_SYN_ZERO_SKIP_EN
    output logic                 syn_skip,
`endif
    output logic                 frm_err
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    localparam logic [5:0] LP_LAST = 6'(N - 1);

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [6*NSYM-1:0]   r_acc;
    logic [6*NSYM-1:0]   r_syn_out;
    logic                r_syn_nz;
    logic                r_syn_vld;
    logic                r_frm_err;
`ifdef RS_SYN_ZERO_SKIP_EN
    logic                r_syn_skip;
`endif

    logic [6*NSYM-1:0]   w_next;
    logic [6*NSYM-1:0]   w_done;
    logic                w_done_nz;
    logic                w_last;
    logic                w_done_evt;

    // Constant multiply by alpha^p as a chain of xtime steps; unrolls to a pure XOR network.
    function automatic logic [5:0] f_mul_alpha_pow(input logic [5:0] x, input int p);
        logic [5:0] v;
        v = x;
        for (int k = 0; k < 16; k++) begin
            if (k < p) begin
                v = {v[4:0], 1'b0} ^ {4'b0000, v[5], v[5]};
            end
        end
        return v;
    endfunction

    for (genvar j = 1; j <= NSYM; j++) begin : g_horner
        assign w_next[6*j-1 -: 6] = f_mul_alpha_pow(r_acc[6*j-1 -: 6], j) ^ din;
    end

    assign w_last     = din_vld && !sop && (r_state == S_ACC) && (r_cnt == LP_LAST);
    assign w_done_evt = w_last || (din_vld && sop && (N == 1));

    // A single-symbol codeword completes on its sop symbol, so every S_j is that symbol.
    always_comb begin
        w_done = w_next;
        if (din_vld && sop) begin
            w_done = {NSYM{din}};
        end
        w_done_nz = |w_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_syn_out  <= '0;
            r_syn_nz   <= 1'b0;
            r_syn_vld  <= 1'b0;
            r_frm_err  <= 1'b0;
`ifdef RS_SYN_ZERO_SKIP_EN
            r_syn_skip <= 1'b0;
`endif
        end else begin
            r_syn_vld <= 1'b0;
            r_frm_err <= 1'b0;
            if (din_vld) begin
                if (sop) begin
                    r_frm_err <= (r_state == S_ACC);
                    r_acc     <= {NSYM{din}};
                    r_cnt     <= 6'd1;
                    r_state   <= S_ACC;
                end else if (r_state == S_IDLE) begin
                    r_frm_err <= 1'b1;
                end else begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 6'd1;
                end
            end
            // Completion overrides the accumulate/start updates above.
            if (w_done_evt) begin
                r_syn_out <= w_done;
                r_syn_nz  <= w_done_nz;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_state   <= S_IDLE;
`ifdef RS_SYN_ZERO_SKIP_EN
                r_syn_vld  <= w_done_nz;
                r_syn_skip <= !w_done_nz;
`else
                r_syn_vld <= 1'b1;
`endif
            end
        end
    end

    assign busy    = (r_state == S_ACC);
    assign syn_vld = r_syn_vld;
    assign syn_out = r_syn_out;
    assign syn_nz  = r_syn_nz;
    assign frm_err = r_frm_err;
`ifdef RS_SYN_ZERO_SKIP_EN
    assign syn_skip = r_syn_skip;
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// Bench for rs_syndrome: directed codewords, scoreboard queue popped by a syn_vld monitor.
// Handshake: a syndrome vector is consumed exactly on a cycle where syn_vld is high; no backpressure.
module tb_rs_syndrome;
  localparam int N    = 63;
  localparam int NSYM = 8;
  localparam int W    = 6 * NSYM;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din_vld;
  logic [5:0]   din;
  logic         sop;
  logic         busy;
  logic         syn_vld;
  logic [W-1:0] syn_out;
  logic         syn_nz;
  logic         frm_err;
`ifdef RS_SYN_ZERO_SKIP_EN
  logic         syn_skip;
`endif

  rs_syndrome #(.N(N), .NSYM(NSYM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_vld (din_vld),
    .din     (din),
    .sop     (sop),
    .busy    (busy),
    .syn_vld (syn_vld),
    .syn_out (syn_out),
    .syn_nz  (syn_nz),
`ifdef RS_SYN_ZERO_SKIP_EN
    .syn_skip(syn_skip),
`endif
    .frm_err (frm_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_chk = 0;
  int         n_pass = 0;
  logic [W:0] exp_q[$];
  int         cyc_q[$];
  int         frm_seen = 0;
  int         frm_exp = 0;
  bit         pend_vld = 0;

  logic [5:0] exp_t[0:62];
  int         log_t[0:63];
  logic [5:0] g[0:8];
  logic [5:0] cw[0:62];
  logic [W-1:0] v_x62;
  logic [W-1:0] v_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    if (a == 0 || b == 0) return 6'd0;
    return exp_t[(log_t[a] + log_t[b]) % 63];
  endfunction

  // Direct evaluation r(alpha^j) = sum r_d * alpha^(d*j) via power tables.
  function automatic logic [W-1:0] model_syn();
    logic [W-1:0] res;
    logic [5:0]   s;
    res = '0;
    for (int j = 1; j <= NSYM; j++) begin
      s = 6'd0;
      for (int d = 0; d < N; d++)
        if (cw[d] != 0) s ^= exp_t[(log_t[cw[d]] + d * j) % 63];
      res[6*j-1 -: 6] = s;
    end
    return res;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    int         c;
    if (frm_err) frm_seen++;
    if (syn_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_syn_vld: got syn_out %0h with empty queue (t=%0t)", syn_out, $time);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("syn_out", syn_out, e[W-1:0]);
        check("syn_nz", syn_nz, e[W]);
        check("vld_cycle", cyc, c);
`ifdef RS_SYN_ZERO_SKIP_EN
        check("syn_skip", syn_skip, 0);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [W-1:0] v, input logic nz);
`ifdef RS_SYN_ZERO_SKIP_EN
    if (v == '0) begin
      pend_vld = 0;
      return;
    end
`endif
    exp_q.push_back({nz, v});
    pend_vld = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input logic [5:0] d, input logic s);
    din_vld = 1'b1;
    din     = d;
    sop     = s;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    sop     = 1'b0;
    din     = 6'd0;
  endtask

  // Sends cw highest degree first; syn_vld expected on the cycle after the last capture.
  task automatic send_cw(input bit gaps);
    for (int t = 0; t < N; t++) begin
      if (gaps && t > 0) idle($urandom_range(0, 2));
      send_sym(cw[N-1-t], t == 0);
    end
    if (pend_vld) cyc_q.push_back(cyc);
    pend_vld = 0;
  endtask

  task automatic clear_cw();
    for (int d = 0; d < N; d++) cw[d] = 6'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] v;
    rst_n = 1'b0; din_vld = 1'b0; sop = 1'b0; din = 6'd0;

    v = 6'd1;
    for (int i = 0; i < 63; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = {v[4:0], 1'b0} ^ {4'b0000, v[5], v[5]};
    end
    for (int k = 0; k <= 8; k++) g[k] = 6'd0;
    g[0] = 6'd1;
    for (int j = 1; j <= NSYM; j++) begin
      for (int k = j; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], exp_t[j]);
      g[0] = gf_mul(g[0], exp_t[j]);
    end
    // alpha^62..alpha^55 for r = x^62, hand-derived by repeated division by alpha.
    v_x62 = {6'd46, 6'd31, 6'd62, 6'd63, 6'd61, 6'd57, 6'd49, 6'd33};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_syn_vld", syn_vld, 0);
    check("rst_syn_out", syn_out, 0);
    check("rst_syn_nz", syn_nz, 0);
    check("rst_frm_err", frm_err, 0);
    rst_n = 1'b1;
    idle(2);

    // all-zero codeword
    clear_cw();
    push_exp('0, 1'b0);
    send_cw(0);
    idle(3);
    check("frm_t1", frm_seen, frm_exp);

    // r = x^62
    clear_cw();
    cw[62] = 6'd1;
    push_exp(v_x62, 1'b1);
    send_cw(0);
    idle(2);

    // r = 5 (constant term only)
    clear_cw();
    cw[0] = 6'd5;
    push_exp({NSYM{6'd5}}, 1'b1);
    send_cw(0);
    idle(2);

    // g(x) then x^20*g(x), random gaps, back-to-back
    clear_cw();
    for (int k = 0; k <= 8; k++) cw[k] = g[k];
    push_exp('0, 1'b0);
    send_cw(1);
    clear_cw();
    for (int k = 0; k <= 8; k++) cw[k+20] = g[k];
    push_exp('0, 1'b0);
    send_cw(1);
    idle(3);
    check("frm_b2b", frm_seen, frm_exp);

    // abort: sop again at symbol 10
    for (int i = 0; i < 9; i++) send_sym(6'd7, i == 0);
    check("busy_mid", busy, 1);
    frm_exp++;
    clear_cw();
    cw[62] = 6'd1;
    push_exp(v_x62, 1'b1);
    send_cw(0);
    idle(2);
    check("frm_abort", frm_seen, frm_exp);

    // stray symbol in IDLE
    send_sym(6'd9, 1'b0);
    frm_exp++;
    idle(2);
    check("frm_idle_drop", frm_seen, frm_exp);
    check("busy_after_drop", busy, 0);

    // reset at symbol 30, then a full random codeword
    for (int d = 0; d < N; d++) cw[d] = 6'($urandom_range(0, 63));
    for (int t = 0; t < 30; t++) send_sym(cw[N-1-t], t == 0);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_syn_out", syn_out, 0);
    check("mrst_syn_nz", syn_nz, 0);
    check("mrst_syn_vld", syn_vld, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    v_m = model_syn();
    push_exp(v_m, |v_m);
    send_cw(1);
    idle(3);

    check("frm_final", frm_seen, frm_exp);
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rs_syndrome.md
Name: rs_syndrome

Overview:
- Receive-side front end of the RS(63,k) decoder over GF(2^6), primitive polynomial x^6+x+1; counterpart of the encoder's parity path.
- Accepts one 6-bit received symbol per valid cycle, highest-degree symbol first.
- Accumulates syndromes S_j = r(alpha^j), j=1..NSYM, by Horner's rule.
- Presents the full syndrome vector one cycle after the last symbol, for the key-equation solver.

Parameters:
- N, 63, codeword length in symbols (2..63).
- NSYM, 8, number of syndromes = 2T (2..16, even).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din_vld  in  1  symbol valid
- din  in  6  received symbol, GF(64) polynomial basis, bit0 = alpha^0
- sop  in  1  first symbol of codeword; qualified by din_vld
- busy  out  1  codeword in progress
- syn_vld  out  1  one-cycle pulse: syn_out updated
- syn_out  out  6*NSYM  S_1 in [5:0], S_j in [6j-1:6j-6]
- syn_nz  out  1  any syndrome nonzero; valid with syn_vld, held
- frm_err  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset: all outputs and accumulators 0, count 0, state IDLE. Async assert; synchronous release to clk.
- States: IDLE, ACC.
- IDLE:
  - din_vld&sop: acc_j <= din for all j, cnt <= 1, go ACC.
  - din_vld&!sop: symbol dropped, frm_err pulses next cycle, stay IDLE.
- ACC:
  - din_vld&!sop: acc_j <= acc_j*alpha^j ^ din, cnt++.
  - No din_vld: hold acc_j and cnt; gaps of any length are allowed.
- Last symbol (din_vld&!sop in ACC with cnt==N-1):
  - Next cycle: syn_out_j = acc_j*alpha^j ^ din, syn_nz = |syn_out, syn_vld = 1.
  - State returns to IDLE and acc clears.
- Back-to-back codewords: sop may arrive the cycle after the last symbol with no gap.
- Abort: din_vld&sop in ACC abandons the partial codeword. frm_err pulses, no syn_vld, and the symbol starts a new codeword (acc_j <= din, cnt <= 1).
- N==1 corner: sop on a single-symbol codeword completes immediately; syn_vld is issued next cycle with all S_j = din.
- busy = (state==ACC).
- syn_out and syn_nz hold their values until the next syn_vld. They are never altered by aborts or framing errors.
- Constant multipliers by alpha^j:
  - Combinational XOR networks derived from the primitive polynomial; no lookup ROM.
  - alpha^6 = alpha+1.
- Reset mid-codeword: accumulation discarded, all outputs return to reset values.
- No backpressure: downstream must sample syn_out when syn_vld is high, or later before the next syn_vld.

Optional Feature:
- Macro: RS_SYN_ZERO_SKIP_EN.
- Defined: adds output syn_skip (1 bit).
  - Asserted with syn_vld when all syndromes are zero; held like syn_out.
  - In that case syn_vld is suppressed, so the solver is not started and the codeword is forwarded unchanged.
  - syn_out is still updated (all zero).
- Not defined: syn_vld is issued for every completed codeword, and the syn_skip port does not exist.

Test Plan:
- Default params, 63 zero symbols (sop on first) -> syn_vld 1 cycle after 63rd symbol; syn_out all 0; syn_nz=0; frm_err never set.
- sop with din=1, then 62 zeros (r=x^62) -> S_1=33 (alpha^62=alpha^5+1); S_j=alpha^(62j) for j=2..8; syn_nz=1.
- 62 zeros then din=5 as last symbol -> every S_j=5; syn_nz=1.
- Valid encoder codeword, random din_vld gaps, back-to-back with a second codeword -> two syn_vld pulses, both all-zero syndromes, no idle cycle needed between codewords.
- sop again at symbol 10 mid-codeword -> frm_err pulse; syn_vld only 63 symbols after the second sop. Also: din_vld without sop in IDLE -> frm_err, dropped.
- rst_n low at symbol 30 -> busy, syn_out, syn_nz = 0 asynchronously; next full codeword yields correct syndromes.
